// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side streaming master.
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;
  typedef logic [2:0] lvl_t;

  // Words held or in flight after this cycle: buffered + arriving - leaving.
  function automatic lvl_t next_level(input occ_t occ, input logic arrive, input logic leave);
    return lvl_t'(occ) + lvl_t'(arrive) - lvl_t'(leave);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry register buffer that absorbs the FIFO read latency; the head drives the stream.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              pop_i,
  output occ_t              occ_o,
  output logic              valid_o,
  output logic [DWIDTH-1:0] head_o
);

  typedef logic [DWIDTH-1:0] data_t;

  data_t head_q, head_d;
  data_t tail_q, tail_d;
  occ_t  occ_q, occ_d;
  logic  valid_q, valid_d;
  lvl_t  lvl;

  always_comb begin
    lvl     = next_level(occ_q, wr_i, pop_i);
    occ_d   = lvl[1:0];
    valid_d = (lvl != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    // A write during a pop with one entry goes straight to the head to keep order.
    if (pop_i) begin
      if (occ_q == 2'd2) begin
        head_d = tail_q;
        if (wr_i) tail_d = wr_data_i;
      end else if (wr_i) begin
        head_d = wr_data_i;
      end
    end else if (wr_i) begin
      if (occ_q == 2'd0) head_d = wr_data_i;
      else               tail_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign occ_o   = occ_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (srst_i)
    lvl <= lvl_t'(BUF_DEPTH));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (srst_i)
    !(pop_i && occ_q == 2'd0));

endmodule

// File: rtl/fifo_stream_reader.sv
// Autonomous FIFO reader presenting words as a valid/ready stream at one word per cycle.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rddata_i,
  output logic              fifo_rd_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CWIDTH-1:0] words_cnt_o
);

  logic              pend_q, pend_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  occ_t              occ;
  logic              pop;
  lvl_t              lvl_after;

  assign pop = m_valid_o & m_ready_i;

  // Only read when the word landing next cycle is guaranteed a free slot.
  always_comb begin
    lvl_after = next_level(occ, pend_q, pop);
    fifo_rd_o = ~srst_i & ~fifo_empty_i & (lvl_after < lvl_t'(BUF_DEPTH));
    pend_d    = fifo_rd_o;
    cnt_d     = cnt_q + {{(CWIDTH-1){1'b0}}, pop};
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  rd_skid_buf #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .wr_i     (pend_q),
    .wr_data_i(fifo_rddata_i),
    .pop_i    (pop),
    .occ_o    (occ),
    .valid_o  (m_valid_o),
    .head_o   (m_data_o)
  );

  assign words_cnt_o = cnt_q;

  a_hold_under_stall : assert property (@(posedge clk_i) disable iff (srst_i)
    (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o)));

  a_no_read_when_empty : assert property (@(posedge clk_i) disable iff (srst_i)
    !(fifo_rd_o && fifo_empty_i));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: registered-FIFO model, in-order scoreboard, hand-computed checks.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          fifoEmptyModel = 1'b1;
  logic          holdNotEmpty = 1'b0;
  logic          fifoEmpty;
  logic [DW-1:0] fifoData = '0;
  logic          mReady = 1'b0;
  logic          fifoRd;
  logic          mValid;
  logic [DW-1:0] mData;
  logic [CW-1:0] wordsCnt;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] expQ[$];

  logic          rdSeen = 1'b0;
  logic          emptySeen = 1'b1;
  logic          validSeen = 1'b0;
  logic          readySeen = 1'b0;
  logic [DW-1:0] dataSeen = '0;

  int inFlight = 0;
  int readsIssued = 0;
  int compared = 0;
  int mismatched = 0;
  int base;
  int pushed;
  logic drained;

  assign fifoEmpty = fifoEmptyModel & ~holdNotEmpty;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DWIDTH(DW),
    .CWIDTH(CW)
  ) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .fifo_empty_i (fifoEmpty),
    .fifo_rddata_i(fifoData),
    .fifo_rd_o    (fifoRd),
    .m_data_o     (mData),
    .m_valid_o    (mValid),
    .m_ready_i    (mReady),
    .words_cnt_o  (wordsCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] word);
    fifoQ.push_back(word);
    expQ.push_back(word);
  endtask

  // Snapshot everything just before the rising edge so the model never races the DUT.
  always @(negedge clk) begin
    #4;
    rdSeen    = fifoRd;
    emptySeen = fifoEmpty;
    validSeen = mValid;
    readySeen = mReady;
    dataSeen  = mData;
  end

  always @(posedge clk) begin
    if (srst) begin
      fifoQ.delete();
      expQ.delete();
      fifoEmptyModel <= 1'b1;
      fifoData       <= '0;
      inFlight = 0;
    end else begin
      if (rdSeen) begin
        readsIssued++;
        checkOutput("rd while empty", 32'(emptySeen), 32'd0);
        if (fifoQ.size() != 0) fifoData <= fifoQ.pop_front();
      end
      if (validSeen && readySeen) begin
        checkOutput("beat expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) checkOutput("stream data", 32'(dataSeen), 32'(expQ.pop_front()));
      end
      inFlight = inFlight + int'(rdSeen) - int'(validSeen && readySeen);
      checkOutput("buffered <= 2", 32'(inFlight <= 2), 32'd1);
      fifoEmptyModel <= (fifoQ.size() == 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset with FIFO reporting data");
    srst = 1'b1;
    holdNotEmpty = 1'b1;
    mReady = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      checkOutput("reset rd", 32'(fifoRd), 32'd0);
      checkOutput("reset valid", 32'(mValid), 32'd0);
      checkOutput("reset cnt", 32'(wordsCnt), 32'd0);
    end
    @(negedge clk);
    holdNotEmpty = 1'b0;

    $display("[TB] streaming 0x01..0x10 with ready held");
    @(negedge clk);
    srst = 1'b0;
    for (int w = 1; w <= 16; w++) applyStimulus(DW'(w));
    @(negedge clk); #2;
    checkOutput("stream valid c1", 32'(mValid), 32'd0);
    checkOutput("stream rd c1", 32'(fifoRd), 32'd1);
    @(negedge clk); #2;
    checkOutput("stream valid c2", 32'(mValid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #2;
      checkOutput("stream beat valid", 32'(mValid), 32'd1);
      checkOutput("stream beat data", 32'(mData), 32'(k + 1));
    end
    @(negedge clk); #2;
    checkOutput("stream valid end", 32'(mValid), 32'd0);
    checkOutput("stream cnt", 32'(wordsCnt), 32'd16);
    checkOutput("stream rd end", 32'(fifoRd), 32'd0);

    $display("[TB] back-pressure 0xA0..0xA7");
    @(negedge clk);
    mReady = 1'b0;
    base = readsIssued;
    for (int w = 0; w < 8; w++) applyStimulus(DW'(8'hA0 + w));
    repeat (2) @(negedge clk);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk); #2;
      checkOutput("bp valid held", 32'(mValid), 32'd1);
      checkOutput("bp data held", 32'(mData), 32'hA0);
    end
    checkOutput("bp reads issued", 32'(readsIssued - base), 32'd2);
    checkOutput("bp rd stopped", 32'(fifoRd), 32'd0);
    mReady = 1'b1;
    drained = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #2;
      if (expQ.size() == 0 && !mValid) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("bp drained", 32'(drained), 32'd1);
    checkOutput("bp cnt", 32'(wordsCnt), 32'd24);

    $display("[TB] random stall over 240 words");
    pushed = 0;
    drained = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      mReady = 1'($urandom_range(0, 1));
      if (pushed < 240 && $urandom_range(0, 1) == 1) begin
        applyStimulus(DW'($urandom));
        pushed++;
      end
      if (pushed == 240 && expQ.size() == 0 && !mValid) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("rand drained", 32'(drained), 32'd1);
    checkOutput("rand cnt wrap", 32'(wordsCnt), 32'd8);
    mReady = 1'b1;

    $display("[TB] single word through an empty FIFO");
    @(negedge clk);
    applyStimulus(8'h5A);
    @(negedge clk); #2;
    checkOutput("single rd", 32'(fifoRd), 32'd1);
    @(negedge clk); #2;
    checkOutput("single rd off", 32'(fifoRd), 32'd0);
    checkOutput("single valid early", 32'(mValid), 32'd0);
    @(negedge clk); #2;
    checkOutput("single valid", 32'(mValid), 32'd1);
    checkOutput("single data", 32'(mData), 32'h5A);
    @(negedge clk); #2;
    checkOutput("single valid drop", 32'(mValid), 32'd0);
    checkOutput("single rd idle", 32'(fifoRd), 32'd0);
    checkOutput("single cnt", 32'(wordsCnt), 32'd9);

    $display("[TB] reset with two words buffered");
    @(negedge clk);
    mReady = 1'b0;
    applyStimulus(8'hB0);
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    repeat (4) @(negedge clk);
    #2;
    checkOutput("pre-reset valid", 32'(mValid), 32'd1);
    checkOutput("pre-reset data", 32'(mData), 32'hB0);
    srst = 1'b1;
    @(negedge clk); #2;
    checkOutput("mid-reset valid", 32'(mValid), 32'd0);
    checkOutput("mid-reset cnt", 32'(wordsCnt), 32'd0);
    checkOutput("mid-reset rd", 32'(fifoRd), 32'd0);
    srst = 1'b0;
    mReady = 1'b1;
    for (int w = 0; w < 4; w++) applyStimulus(DW'(8'hC0 + w));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2;
      checkOutput("post-reset valid", 32'(mValid), 32'd1);
      checkOutput("post-reset data", 32'(mData), 32'(8'hC0 + k));
    end
    @(negedge clk); #2;
    checkOutput("post-reset valid end", 32'(mValid), 32'd0);
    checkOutput("post-reset cnt", 32'(wordsCnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
